// File: rtl/lut_interp_sequencer_pkg.sv
// Shared definitions for the activation-function LUT interpolator path.
// idx_of() is also used by the LUT generator, so keep the mapping here.
package lut_interp_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FRAC_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BASE = 3'd1,
        RD_NEXT = 3'd2,
        WAIT    = 3'd3,
        OUT     = 3'd4
    } state_t;

    // Signed integer part of x, offset to unsigned by flipping its MSB.
    function automatic logic [31:0] idx_of(input logic [31:0] x,
                                           input int data_w,
                                           input int frac_w);
        logic [31:0] mask;
        logic [31:0] msb;
        mask   = (32'd1 << (data_w - frac_w)) - 32'd1;
        msb    = 32'd1 << (data_w - frac_w - 1);
        idx_of = ((x >> frac_w) & mask) ^ msb;
    endfunction

endpackage

// File: rtl/lut_interp_sequencer.sv
// Splits x into LUT index / remainder, reads table[idx] and table[idx+1] from an
// external synchronous ROM and hands the operands to the interpolator (4-cycle latency).
module lut_interp_sequencer
    import lut_interp_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_x,
    output logic                     rom_rd,
    output logic [DATA_W-FRAC_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        base,
    output logic [DATA_W-1:0]        next_data,
    output logic [DATA_W-1:0]        change,
    output logic [DATA_W-1:0]        remaining
);

    localparam int ADDR_W = DATA_W - FRAC_W;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   idx_x;
    logic [ADDR_W-1:0]   idx_sat;
    logic [DATA_W-1:0]   rem_x;
    logic [31:0]         idx_wide;

    assign idx_wide = idx_of(32'(in_x), DATA_W, FRAC_W);
    assign idx_x    = idx_wide[ADDR_W-1:0];
    assign rem_x    = {{(DATA_W-FRAC_W){1'b0}}, in_x[FRAC_W-1:0]};
    // The top entry re-reads itself so next_data == base there.
    assign idx_sat  = (idx == {ADDR_W{1'b1}}) ? idx : idx + 1'b1;

    assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            out_valid <= 1'b0;
            base      <= '0;
            next_data <= '0;
            change    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= RD_BASE;
                        idx       <= idx_x;
                        remaining <= rem_x;
                        rom_rd    <= 1'b1;
                        rom_addr  <= idx_x;
                    end
                end
                RD_BASE: begin
                    state    <= RD_NEXT;
                    rom_addr <= idx_sat;
                end
                RD_NEXT: begin
                    base   <= rom_data;
                    rom_rd <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    next_data <= rom_data;
                    change    <= rom_data - base;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            state     <= RD_BASE;
                            idx       <= idx_x;
                            remaining <= rem_x;
                            rom_rd    <= 1'b1;
                            rom_addr  <= idx_x;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lut_interp_sequencer.md
Name: lut_interp_sequencer

Overview:
- Producer side of the activation-function interpolator interface. Takes a fixed-point neuron input x, splits it into a table index and a fractional remainder, and reads two adjacent entries from a synchronous activation LUT.
- Presents base / next_data / change / remaining to the downstream interpolator under a valid/ready handshake.
- Sits between the layer accumulator output and the interpolator inside each layer's activation function.

Parameters:
- DATA_W, 8, width of x, of table entries and of all interpolator-side data ports (signed two's complement).
- FRAC_W, 4, fractional bits of x; also the interpolator's right-shift amount.
- ADDR_W, DATA_W-FRAC_W (=4), LUT address width (derived; must not be overridden independently).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: x valid.
- in_ready, output, 1: block can accept x.
- in_x, input, DATA_W: signed input, Q(ADDR_W).(FRAC_W).
- rom_rd, output, 1: LUT read enable.
- rom_addr, output, ADDR_W: LUT address.
- rom_data, input, DATA_W: signed LUT data, valid the cycle after rom_rd.
- out_valid, output, 1: interpolator operands valid.
- out_ready, input, 1: interpolator accepts.
- base, output, DATA_W: signed table[idx].
- next_data, output, DATA_W: signed table[idx+1], saturated at the top entry.
- change, output, DATA_W: signed next_data-base, wraps modulo 2^DATA_W.
- remaining, output, DATA_W: in_x[FRAC_W-1:0], zero-extended.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a rising edge:
  - state goes to IDLE;
  - out_valid, rom_rd, rom_addr, base, next_data, change and remaining all go to 0;
  - in_ready goes to 1 on the first cycle after reset.
- Index mapping: idx = {~in_x[DATA_W-1], in_x[DATA_W-2:FRAC_W]}, i.e. the signed integer part offset to unsigned. So x=-8.0 gives idx 0 and x=+7.x gives idx 15. idx and remainder are latched at the accept edge.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, go to RD_BASE.
  - RD_BASE: rom_rd=1, rom_addr=idx. Go to RD_NEXT.
  - RD_NEXT: rom_rd=1, rom_addr=min(idx+1, 2^ADDR_W-1). Capture rom_data into base. Go to WAIT.
  - WAIT: rom_rd=0. Capture rom_data into next_data. Go to OUT.
  - OUT: out_valid=1 and all four operands stable. Compute change combinationally from the registered values, or register it on entry to OUT; either is acceptable.
- Leaving OUT:
  - out_ready=1 and in_valid=0: go to IDLE, out_valid drops on the next cycle.
  - out_ready=1 and in_valid=1: in_ready=1 this cycle, the new x is accepted and the state goes directly to RD_BASE.
  - in_ready is 0 in OUT whenever out_ready=0.
- Latency and throughput: handshake in cycle t gives out_valid=1 in cycle t+4. Sustained throughput is one result per 4 cycles.
- Top-entry saturation: when idx=2^ADDR_W-1, the second read re-reads idx, so next_data=base, change=0, and latency is unchanged.
- Backpressure: while out_valid=1 and out_ready=0, every output holds its value and no LUT read is issued.
- rom_rd is never asserted outside RD_BASE and RD_NEXT.
- Reset mid-operation abandons the transaction; no out_valid is produced for it.
- change is a raw DATA_W-bit difference with no saturation. The downstream interpolator applies $signed to it.

Decomposition:
- Shared package (activation function), holding:
  - DATA_W and FRAC_W defaults;
  - the state enum {IDLE, RD_BASE, RD_NEXT, WAIT, OUT};
  - an idx_of(x) function implementing the MSB-flip mapping, shared with the LUT generator.
- No sub-module is needed. The LUT ROM stays external so the table can be swapped per activation function.

Test Plan:
Bench ROM: table[i] = 8*i - 64.
- Mid-range input: in_x=0x00 -> rom_addr 8 then 9; at t+4 base=0, next_data=8, change=8, remaining=0.
- Fractional remainder: in_x=0x23 -> idx 10; base=16, next_data=24, change=8, remaining=3.
- Top and bottom entries:
  - in_x=0x7F -> both reads at address 15; base=next_data=56, change=0, remaining=15.
  - in_x=0x80 -> base=-64, next_data=-56.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid -> operands stable, in_ready=0, rom_rd=0.
  - Then out_ready=1 with in_valid=1 (in_x=0x10) -> accepted that cycle; next out_valid exactly 4 cycles later with base=8.
- Reset mid-operation: assert rst in RD_NEXT -> next cycle all outputs 0 and in_ready=1; no out_valid follows. A subsequent in_x=0x00 completes normally.
- Random soak: 1000 random in_x with random out_ready.
  - Each result must equal the reference-model {table[idx], table[min(idx+1,15)], difference, x[3:0]}.
  - No drops or duplicates.
